// File: rtl/jtopll_mmr_wr.sv
// ---------------------------------------------------------------------------
// jtopll_mmr_wr
//   CPU-side writer for the OPLL register file. Turns YM2413-style
//   address/data bus writes into update strobes for the channel/patch
//   register block. It also owns the rhythm (0x0E) and test (0x0F) registers.
//
//   A channel-register strobe (fnumlo/fnumhi/inst) is held until HOLD_ZEROS
//   qualified frame markers (cen & zero) have been seen. This guarantees
//   that every slot of the pipeline has passed, so the matching slot
//   captures the write.
//
//   State table
//     state   | meaning
//     --------+-----------------------------------------------------------
//     ST_IDLE | no channel write pending; channel/patch writes accepted
//     ST_WAIT | channel strobe held, counting cen&zero pulses; busy=1
//
// Ports
//   rst          async reset, active-high
//   clk          system clock
//   cen          slot pipeline clock enable
//   cs_n, wr_n   active-low chip select / write strobe
//   addr         0 = address latch, 1 = data write
//   din[7:0]     CPU data bus
//   zero         frame marker from the slot counter
//   dout[7:0]    data byte presented to the register file
//   sel_group    channel / 3
//   sel_sub      channel % 3, or the patch byte index for 0x00-0x07
//   up_fnumlo    strobe for regs 0x10-0x18
//   up_fnumhi    strobe for regs 0x20-0x28
//   up_inst      strobe for regs 0x30-0x38
//   up_original  one-clk strobe for regs 0x00-0x07
//   rhy_en       reg 0x0E bit 5
//   rhy_kon      reg 0x0E bits 4:0 (BD,SD,TOM,CYM,HH)
//   test         reg 0x0F
//   busy         channel-register write in progress
// ---------------------------------------------------------------------------
module jtopll_mmr_wr #(
    parameter int HOLD_ZEROS = 2
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
    input  logic       zero,
    output logic [7:0] dout,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_inst,
    output logic       up_original,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic [7:0] test,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [7:0] addr_latch;
    logic       wr_act;
    logic       wr_prev;
    logic       wr_edge;
    logic       data_wr;
    logic       chan_range;
    logic       chan_wr;
    logic       patch_wr;
    logic       hold_done;
    // Register bank of the pending channel write: 1=fnumlo, 2=fnumhi, 3=inst
    logic [1:0] bank;
    logic [1:0] zero_cnt;
    logic [1:0] ch_group;
    logic [2:0] ch_sub;

    // Only the first cycle of a low strobe acts, so a CPU that holds
    // wr_n low for several clocks produces a single register update.
    assign wr_act  = ~cs_n & ~wr_n;
    assign wr_edge = wr_act & ~wr_prev;
    assign data_wr = wr_edge & addr;

    assign chan_range = ((addr_latch[7:4] == 4'h1) ||
                         (addr_latch[7:4] == 4'h2) ||
                         (addr_latch[7:4] == 4'h3)) &&
                        (addr_latch[3:0] <= 4'd8);

    // Patch and channel writes both change dout/sel_*, which must stay stable
    // while a channel strobe is held. Both are therefore dropped outside IDLE.
    assign chan_wr  = data_wr & chan_range & (state == ST_IDLE);
    assign patch_wr = data_wr & (addr_latch[7:3] == 5'd0) & (state == ST_IDLE);

    // Counting only starts in WAIT, so a zero that coincides with the
    // accepting write edge is not part of the hold.
    assign hold_done = (state == ST_WAIT) & cen & zero &
                       (zero_cnt == 2'(HOLD_ZEROS - 1));

    // Channel number 0..8 split into group (ch/3) and sub-index (ch%3)
    always_comb begin
        ch_group = 2'd0;
        ch_sub   = 3'd0;
        case (addr_latch[3:0])
            4'd0: begin ch_group = 2'd0; ch_sub = 3'd0; end
            4'd1: begin ch_group = 2'd0; ch_sub = 3'd1; end
            4'd2: begin ch_group = 2'd0; ch_sub = 3'd2; end
            4'd3: begin ch_group = 2'd1; ch_sub = 3'd0; end
            4'd4: begin ch_group = 2'd1; ch_sub = 3'd1; end
            4'd5: begin ch_group = 2'd1; ch_sub = 3'd2; end
            4'd6: begin ch_group = 2'd2; ch_sub = 3'd0; end
            4'd7: begin ch_group = 2'd2; ch_sub = 3'd1; end
            4'd8: begin ch_group = 2'd2; ch_sub = 3'd2; end
            default: begin ch_group = 2'd0; ch_sub = 3'd0; end
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (chan_wr)   state_nx = ST_WAIT;
            ST_WAIT: if (hold_done) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM: outputs. Strobes derive from the registered state, so the strobe
    // and busy rise and fall on the same edge.
    always_comb begin
        busy      = (state == ST_WAIT);
        up_fnumlo = (state == ST_WAIT) && (bank == 2'd1);
        up_fnumhi = (state == ST_WAIT) && (bank == 2'd2);
        up_inst   = (state == ST_WAIT) && (bank == 2'd3);
    end

    // Bus capture, hold counter and register datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_prev     <= 1'b0;
            addr_latch  <= 8'd0;
            zero_cnt    <= 2'd0;
            bank        <= 2'd0;
            dout        <= 8'd0;
            sel_group   <= 2'd0;
            sel_sub     <= 3'd0;
            up_original <= 1'b0;
            rhy_en      <= 1'b0;
            rhy_kon     <= 5'd0;
            test        <= 8'd0;
        end else begin
            wr_prev     <= wr_act;
            up_original <= 1'b0;

            // The address latch is accepted even while busy.
            if (wr_edge && !addr) begin
                addr_latch <= din;
            end

            if (state == ST_WAIT) begin
                if (hold_done) begin
                    zero_cnt <= 2'd0;
                end else if (cen && zero) begin
                    zero_cnt <= zero_cnt + 2'd1;
                end
            end

            if (chan_wr) begin
                dout      <= din;
                sel_group <= ch_group;
                sel_sub   <= ch_sub;
                bank      <= addr_latch[5:4];
            end

            if (patch_wr) begin
                dout        <= din;
                sel_group   <= 2'd0;
                sel_sub     <= addr_latch[2:0];
                up_original <= 1'b1;
            end

            if (data_wr && (addr_latch == 8'h0E)) begin
                {rhy_en, rhy_kon} <= din[5:0];
            end

            if (data_wr && (addr_latch == 8'h0F)) begin
                test <= din;
            end
        end
    end

endmodule

// File: tb/tb_jtopll_mmr_wr.sv
module tb_jtopll_mmr_wr;

    localparam int HZ = 2;

    logic       rst = 1'b1;
    logic       clk = 1'b0;
    logic       cen = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       addr = 1'b0;
    logic [7:0] din = 8'd0;
    logic       zero = 1'b0;

    logic [7:0] dout;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic       up_fnumlo, up_fnumhi, up_inst, up_original;
    logic       rhy_en;
    logic [4:0] rhy_kon;
    logic [7:0] test;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    jtopll_mmr_wr #(.HOLD_ZEROS(HZ)) dut (
        .rst(rst), .clk(clk), .cen(cen), .cs_n(cs_n), .wr_n(wr_n),
        .addr(addr), .din(din), .zero(zero),
        .dout(dout), .sel_group(sel_group), .sel_sub(sel_sub),
        .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_inst(up_inst),
        .up_original(up_original), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
        .test(test), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_kind: which channel bank is pending (0 none, 1 fnumlo, 2 fnumhi, 3 inst)
    logic [7:0] m_latch = 0, m_dout = 0, m_test = 0;
    logic [1:0] m_grp = 0;
    logic [2:0] m_sub = 0;
    logic       m_prev = 0, m_orig = 0, m_rhy_en = 0;
    logic [4:0] m_kon = 0;
    int         m_kind = 0, m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_latch = 0; m_dout = 0; m_test = 0; m_grp = 0; m_sub = 0;
            m_prev = 0; m_orig = 0; m_rhy_en = 0; m_kon = 0;
            m_kind = 0; m_cnt = 0;
        end else begin
            logic act, edg, was_busy;
            int   hi, ch;
            act      = !cs_n && !wr_n;
            edg      = act && !m_prev;
            m_prev   = act;
            m_orig   = 0;
            was_busy = (m_kind != 0);
            if (was_busy && cen && zero) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == HZ) begin
                    m_kind = 0;
                    m_cnt  = 0;
                end
            end
            if (edg && !addr) begin
                m_latch = din;
            end else if (edg && addr) begin
                hi = int'(m_latch) / 16;
                ch = int'(m_latch) % 16;
                if (m_latch <= 8'h07) begin
                    if (!was_busy) begin
                        m_dout = din; m_grp = 0; m_sub = m_latch[2:0]; m_orig = 1;
                    end
                end else if (m_latch == 8'h0E) begin
                    m_rhy_en = din[5]; m_kon = din[4:0];
                end else if (m_latch == 8'h0F) begin
                    m_test = din;
                end else if (hi >= 1 && hi <= 3 && ch <= 8 && !was_busy) begin
                    m_dout = din;
                    m_grp  = 2'(ch / 3);
                    m_sub  = 3'(ch % 3);
                    m_kind = hi;
                    m_cnt  = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        chk("dout", dout, m_dout);
        chk("sel_group", 8'(sel_group), 8'(m_grp));
        chk("sel_sub", 8'(sel_sub), 8'(m_sub));
        chk("up_fnumlo", 8'(up_fnumlo), 8'(m_kind == 1));
        chk("up_fnumhi", 8'(up_fnumhi), 8'(m_kind == 2));
        chk("up_inst", 8'(up_inst), 8'(m_kind == 3));
        chk("up_original", 8'(up_original), 8'(m_orig));
        chk("busy", 8'(busy), 8'(m_kind != 0));
        chk("rhy_en", 8'(rhy_en), 8'(m_rhy_en));
        chk("rhy_kon", 8'(rhy_kon), 8'(m_kon));
        chk("test", test, m_test);
    end

    // ---------------- stimulus ----------------
    // Drive a write and return at the negedge right after the sampling edge.
    task automatic drive(input logic a, input logic [7:0] d);
        cs_n = 0; wr_n = 0; addr = a; din = d;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic release_bus();
        cs_n = 1; wr_n = 1;
        @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic a, input logic [7:0] d);
        drive(a, d);
        release_bus();
    endtask

    task automatic pulse(input logic c);
        zero = 1; cen = c;
        @(posedge clk);
        #2;
        zero = 0; cen = 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_test", test, 8'h00);
        @(posedge clk); #2;
        rst = 0;
        @(posedge clk); #2;

        // fnumhi channel 0, hold through first pulse, clear after second
        bus_wr(0, 8'h20);
        drive(1, 8'h15);
        chk("fh_strobe", 8'(up_fnumhi), 8'h01);
        chk("fh_dout", dout, 8'h15);
        chk("fh_grp", 8'(sel_group), 8'h00);
        chk("fh_sub", 8'(sel_sub), 8'h00);
        chk("fh_busy", 8'(busy), 8'h01);
        release_bus();
        pulse(1);
        chk("fh_hold1", 8'(up_fnumhi), 8'h01);
        pulse(1);
        chk("fh_clear", 8'(up_fnumhi), 8'h00);
        chk("fh_busy_clr", 8'(busy), 8'h00);

        // inst channel 7; write during busy ignored; cen=0 zeros ignored
        bus_wr(0, 8'h37);
        bus_wr(1, 8'hA4);
        chk("in_grp", 8'(sel_group), 8'h02);
        chk("in_sub", 8'(sel_sub), 8'h01);
        chk("in_strobe", 8'(up_inst), 8'h01);
        bus_wr(0, 8'h10);
        bus_wr(1, 8'hFF);
        chk("busy_drop_dout", dout, 8'hA4);
        chk("busy_drop_lo", 8'(up_fnumlo), 8'h00);
        pulse(0); pulse(0); pulse(0);
        chk("cen0_busy", 8'(busy), 8'h01);
        pulse(1); pulse(1);
        chk("in_clear", 8'(busy), 8'h00);

        // zero coinciding with the accepting edge does not count
        bus_wr(0, 8'h11);
        zero = 1;
        drive(1, 8'h42);
        zero = 0;
        release_bus();
        pulse(1);
        chk("same_cyc_zero", 8'(busy), 8'h01);
        pulse(1);
        chk("same_cyc_clr", 8'(busy), 8'h00);

        // patch byte
        bus_wr(0, 8'h05);
        drive(1, 8'h3C);
        chk("pt_orig", 8'(up_original), 8'h01);
        chk("pt_sub", 8'(sel_sub), 8'h05);
        chk("pt_dout", dout, 8'h3C);
        chk("pt_busy", 8'(busy), 8'h00);
        release_bus();
        chk("pt_orig_1clk", 8'(up_original), 8'h00);

        // rhythm and test
        bus_wr(0, 8'h0E);
        bus_wr(1, 8'h31);
        chk("rhy_en_lit", 8'(rhy_en), 8'h01);
        chk("rhy_kon_lit", 8'(rhy_kon), 8'h11);
        bus_wr(0, 8'h0F);
        bus_wr(1, 8'h80);
        chk("test_lit", test, 8'h80);

        // ignored addresses
        bus_wr(0, 8'h19);
        bus_wr(1, 8'h55);
        chk("ign19_busy", 8'(busy), 8'h00);
        bus_wr(0, 8'h40);
        bus_wr(1, 8'h66);
        chk("ign40_dout", dout, 8'h3C);

        // held strobes: a single action each
        bus_wr(0, 8'h03);
        drive(1, 8'h77);
        repeat (10) @(posedge clk);
        #2;
        release_bus();
        bus_wr(0, 8'h38);
        drive(1, 8'h12);
        chk("ch8_grp", 8'(sel_group), 8'h02);
        chk("ch8_sub", 8'(sel_sub), 8'h02);
        repeat (3) @(posedge clk);
        #2;
        pulse(1); pulse(1);
        repeat (4) @(posedge clk);
        #2;
        chk("held_no_retrig", 8'(busy), 8'h00);
        release_bus();

        // reset mid-WAIT
        bus_wr(0, 8'h14);
        bus_wr(1, 8'h9A);
        chk("pre_rst_lo", 8'(up_fnumlo), 8'h01);
        rst = 1;
        #1;
        chk("arst_lo", 8'(up_fnumlo), 8'h00);
        chk("arst_busy", 8'(busy), 8'h00);
        chk("arst_dout", dout, 8'h00);
        chk("arst_test", test, 8'h00);
        chk("arst_rhy", 8'(rhy_kon), 8'h00);
        @(posedge clk); #2;
        rst = 0;
        @(posedge clk); #2;
        bus_wr(0, 8'h22);
        bus_wr(1, 8'h5B);
        chk("post_rst_hi", 8'(up_fnumhi), 8'h01);
        chk("post_rst_sub", 8'(sel_sub), 8'h02);
        chk("post_rst_dout", dout, 8'h5B);
        pulse(1); pulse(1);
        chk("post_rst_clr", 8'(busy), 8'h00);

        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtopll_mmr_wr.md
Name: jtopll_mmr_wr

Overview:
- CPU-side writer for the OPLL register file. Decodes YM2413-style address/data bus writes into the update strobes the channel/patch register block consumes: `up_fnumlo`, `up_fnumhi`, `up_inst`, `up_original`, plus `sel_group`, `sel_sub` and the data byte.
- Holds channel-register strobes until the slot pipeline has swept every channel, so a matching slot is guaranteed to capture the write.
- Owns the rhythm (0x0E) and test (0x0F) registers.

Parameters:
- HOLD_ZEROS, 2, number of `zero` pulses (qualified by `cen`) a channel-register strobe stays asserted. Legal range 2..3.

Ports:
- rst  input  1  asynchronous reset, active-high
- clk  input  1  system clock
- cen  input  1  clock enable of the slot pipeline
- cs_n  input  1  chip select, active-low
- wr_n  input  1  write strobe, active-low
- addr  input  1  0 = address latch, 1 = data write
- din  input  8  CPU data bus
- zero  input  1  pipeline frame marker from slot counter
- dout  output  8  data byte presented to the register file
- sel_group  output  2  channel / 3
- sel_sub  output  3  channel % 3; for 0x00-0x07 it is the patch byte index
- up_fnumlo  output  1  strobe for regs 0x10-0x18
- up_fnumhi  output  1  strobe for regs 0x20-0x28
- up_inst  output  1  strobe for regs 0x30-0x38
- up_original  output  1  strobe for regs 0x00-0x07, one clk wide
- rhy_en  output  1  reg 0x0E bit 5
- rhy_kon  output  5  reg 0x0E bits 4:0 (BD,SD,TOM,CYM,HH = bits 4..0)
- test  output  8  reg 0x0F
- busy  output  1  channel-register write in progress

Behaviour:
- Reset: every output is 0, the internal address latch is 0, and the FSM is in IDLE. Reset asserted mid-write aborts the write immediately and drops all strobes.
- Write detect:
  - A write is `cs_n==0 && wr_n==0` sampled on `clk` (not gated by `cen`).
  - An action happens only on the first cycle of an active write, via an edge detect against the previous cycle. A held-low strobe produces one action.
- Address phase (`addr=0`): the address latch takes `din` at the next clk edge. This is accepted even while `busy`.
- Data phase (`addr=1`), decoded on the address latch. Results are registered, so outputs change 1 clk after the edge.
  - 0x00-0x07: `dout<=din`, `sel_sub<=latch[2:0]`, `sel_group<=0`, `up_original=1` for exactly one clk. `busy` is not raised. Accepted even while `busy`, but ignored if it would alter `dout`/`sel_*` while busy, i.e. such a write is dropped when `busy=1`.
  - 0x0E: `{rhy_en,rhy_kon}<=din[5:0]` at once; no strobe, no busy.
  - 0x0F: `test<=din` at once.
  - 0x10-0x18, 0x20-0x28, 0x30-0x38 with `busy=0`:
    - `dout<=din`; with ch=latch[3:0] (0..8), `sel_group<=ch/3` and `sel_sub<=ch%3`.
    - Assert the matching up_* strobe and enter WAIT.
  - Low nibble 9..15 in the 0x1x/0x2x/0x3x ranges, and any other address: ignored.
  - Channel data writes while `busy=1`: dropped entirely. No state change, `dout` is untouched.
- FSM:
  - IDLE → WAIT on an accepted channel write. The strobe rises in the same cycle `busy` rises.
  - WAIT counts `cen && zero` pulses. When the count reaches HOLD_ZEROS, the next state is IDLE: strobe, `busy` and the counter clear together.
  - `dout`, `sel_group` and `sel_sub` stay stable for the whole WAIT.
  - A `zero` without `cen` does not count.
  - `zero` in the same cycle as strobe assertion does not count.
- At most one up_* strobe is active at any time.

Test Plan:
- Reset → all outputs 0. Write addr 0x20, then data 0x15 → `up_fnumhi=1`, `dout=0x15`, `sel_group=0`, `sel_sub=0`, `busy=1`. Both stay asserted through the 1st `cen&zero` pulse and clear after the 2nd.
- Addr 0x37, data 0xA4 → `sel_group=2`, `sel_sub=1`, `up_inst` held. A second data write 0xFF to addr 0x10 during `busy` → ignored: `dout` stays 0xA4, `up_fnumlo` never rises.
- Addr 0x05, data 0x3C → `up_original` high exactly 1 clk, `sel_sub=5`, `dout=0x3C`, `busy=0`.
- Addr 0x0E, data 0x31 → `rhy_en=1`, `rhy_kon=0x11` next clk. Addr 0x0F, data 0x80 → `test=0x80`.
- Addr 0x19 or 0x40, data any → no strobe, no busy. `zero` pulses with `cen=0` during WAIT → no progress. Hold `wr_n` low 10 clks → single action.
- Assert `rst` while WAIT with `up_fnumlo=1` → all outputs 0 immediately; after release, a new write is accepted normally.
